window_gen: RTL and testbench

- Parametrised K×K sliding-window generator for the convolution pipeline.
- Accepts a raster-scan pixel stream of an IMG_W×IMG_H frame and holds KERNEL-1 line buffers plus a K×K window register array.
- Emits a window only when it lies fully inside the image and on the STRIDE grid, tagged with output coordinates.
- Tracks frame position, so downstream MAC arrays need no edge masking.

---
 rtl/window_gen_if.sv | 37 +++
 rtl/window_gen.sv | 199 +++++++++++++++++++
 tb/tb_window_gen.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/window_gen_if.sv
// Pixel-stream / window-stream bundle for the sliding-window generator.
//
// Handshake: there is no back-pressure. A pixel is accepted on every rising
// clock edge where pixel_valid is high; sof is only meaningful in that same
// cycle. On the output side window_valid and frame_done are single-cycle
// pulses, and window/out_row/out_col hold their value until the next emitted
// window.
interface window_gen_if #(
  parameter int DATA_W = 8,
  parameter int KERNEL = 5,
  parameter int IMG_W  = 32,
  parameter int IMG_H  = 32
);
  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;

  logic                              pixel_valid;
  logic                              sof;
  logic signed [DATA_W-1:0]          pixel_in;
  logic                              window_valid;
  logic [KERNEL*KERNEL*DATA_W-1:0]   window;
  logic [ROW_W-1:0]                  out_row;
  logic [COL_W-1:0]                  out_col;
  logic                              frame_done;

  // Pixel source side
  modport master (
    output pixel_valid, sof, pixel_in,
    input  window_valid, window, out_row, out_col, frame_done
  );

  // Window generator side
  modport slave (
    input  pixel_valid, sof, pixel_in,
    output window_valid, window, out_row, out_col, frame_done
  );
endinterface

// File: rtl/window_gen.sv
// K x K sliding-window generator: KERNEL-1 line buffers feed the right-hand
// column of a K x K register window. Frame position and stride phase are
// tracked with counters so only fully-inside, on-grid windows are emitted.
module window_gen #(
  parameter int DATA_W = 8,
  parameter int KERNEL = 5,
  parameter int IMG_W  = 32,
  parameter int IMG_H  = 32,
  parameter int STRIDE = 1
) (
  input  logic         clk,
  input  logic         rst,
  window_gen_if.slave  bus
);
  localparam int K    = KERNEL;
  localparam int NLB  = K - 1;
  localparam int CC_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RC_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int PH_W = (STRIDE > 1) ? $clog2(STRIDE) : 1;

  localparam logic [CC_W-1:0] COL_LAST = CC_W'(IMG_W - 1);
  localparam logic [CC_W-1:0] COL_KM1  = CC_W'(K - 1);
  localparam logic [RC_W-1:0] ROW_LAST = RC_W'(IMG_H - 1);
  localparam logic [RC_W-1:0] ROW_KM1  = RC_W'(K - 1);
  localparam logic [PH_W-1:0] PH_LAST  = PH_W'(STRIDE - 1);

  // Position, stride phase and output index for the pixel presented next
  logic [CC_W-1:0] col_q, col_d;
  logic [RC_W-1:0] row_q, row_d;
  logic [PH_W-1:0] cph_q, cph_d, rph_q, rph_d;
  logic [CC_W-1:0] cidx_q, cidx_d;
  logic [RC_W-1:0] ridx_q, ridx_d;
  // Circular line-buffer pointer; advances once per accepted pixel so every
  // buffer delays by exactly IMG_W accepted pixels, independent of sof.
  logic [CC_W-1:0] ptr_q, ptr_d;

  logic [DATA_W-1:0] lb_q  [NLB][IMG_W];
  logic [DATA_W-1:0] tap   [K];
  logic [DATA_W-1:0] win_q [K][K];
  logic [DATA_W-1:0] win_d [K][K];

  logic            window_valid_q, window_valid_d;
  logic            frame_done_q, frame_done_d;
  logic [RC_W-1:0] out_row_q, out_row_d;
  logic [CC_W-1:0] out_col_q, out_col_d;

  logic            accept, emit;
  logic [CC_W-1:0] eff_col, eff_cidx;
  logic [RC_W-1:0] eff_row, eff_ridx;
  logic [PH_W-1:0] eff_cph, eff_rph;
  logic [K*K*DATA_W-1:0] window_flat;

  assign accept = bus.pixel_valid;

  // Position of the pixel being accepted; sof forces it to (0,0)
  always_comb begin
    eff_col  = bus.sof ? '0 : col_q;
    eff_row  = bus.sof ? '0 : row_q;
    eff_cph  = bus.sof ? '0 : cph_q;
    eff_rph  = bus.sof ? '0 : rph_q;
    eff_cidx = bus.sof ? '0 : cidx_q;
    eff_ridx = bus.sof ? '0 : ridx_q;
  end

  // Advance column/row counters together with their stride phase and index
  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    cph_d  = cph_q;
    rph_d  = rph_q;
    cidx_d = cidx_q;
    ridx_d = ridx_q;
    if (accept) begin
      if (eff_col == COL_LAST) begin
        col_d  = '0;
        cph_d  = '0;
        cidx_d = '0;
        if (eff_row == ROW_LAST) begin
          row_d  = '0;
          rph_d  = '0;
          ridx_d = '0;
        end else begin
          row_d = eff_row + 1'b1;
          if (eff_row < ROW_KM1) begin
            rph_d  = '0;
            ridx_d = '0;
          end else if (eff_rph == PH_LAST) begin
            rph_d  = '0;
            ridx_d = eff_ridx + 1'b1;
          end else begin
            rph_d  = eff_rph + 1'b1;
            ridx_d = eff_ridx;
          end
        end
      end else begin
        col_d  = eff_col + 1'b1;
        row_d  = eff_row;
        rph_d  = eff_rph;
        ridx_d = eff_ridx;
        if (eff_col < COL_KM1) begin
          cph_d  = '0;
          cidx_d = '0;
        end else if (eff_cph == PH_LAST) begin
          cph_d  = '0;
          cidx_d = eff_cidx + 1'b1;
        end else begin
          cph_d  = eff_cph + 1'b1;
          cidx_d = eff_cidx;
        end
      end
    end
  end

  // Line-buffer pointer wraps at IMG_W
  always_comb begin
    ptr_d = ptr_q;
    if (accept) ptr_d = (ptr_q == COL_LAST) ? '0 : ptr_q + 1'b1;
  end

  // Vertical taps: tap[j] is the incoming pixel delayed by j lines
  always_comb begin
    tap[0] = bus.pixel_in;
    for (int j = 0; j < NLB; j++) tap[j+1] = lb_q[j][ptr_q];
  end

  // Shift every window row left and load the newest column from the taps
  always_comb begin
    win_d = win_q;
    if (accept) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++) win_d[r][c] = win_q[r][c+1];
        win_d[r][K-1] = tap[K-1-r];
      end
    end
  end

  // Emission: window fully inside the image and on the stride grid
  always_comb begin
    emit = accept && (eff_col >= COL_KM1) && (eff_row >= ROW_KM1) &&
           (eff_cph == '0) && (eff_rph == '0);
    window_valid_d = emit;
    frame_done_d   = accept && (eff_col == COL_LAST) && (eff_row == ROW_LAST);
    out_row_d      = emit ? eff_ridx : out_row_q;
    out_col_d      = emit ? eff_cidx : out_col_q;
  end

  // Line buffers carry no reset; position logic masks stale contents
  always_ff @(posedge clk) begin
    if (accept) begin
      lb_q[0][ptr_q] <= bus.pixel_in;
      for (int j = 0; j < NLB - 1; j++) lb_q[j+1][ptr_q] <= lb_q[j][ptr_q];
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q          <= '0;
      row_q          <= '0;
      cph_q          <= '0;
      rph_q          <= '0;
      cidx_q         <= '0;
      ridx_q         <= '0;
      ptr_q          <= '0;
      win_q          <= '{default: '0};
      window_valid_q <= 1'b0;
      frame_done_q   <= 1'b0;
      out_row_q      <= '0;
      out_col_q      <= '0;
    end else begin
      col_q          <= col_d;
      row_q          <= row_d;
      cph_q          <= cph_d;
      rph_q          <= rph_d;
      cidx_q         <= cidx_d;
      ridx_q         <= ridx_d;
      ptr_q          <= ptr_d;
      win_q          <= win_d;
      window_valid_q <= window_valid_d;
      frame_done_q   <= frame_done_d;
      out_row_q      <= out_row_d;
      out_col_q      <= out_col_d;
    end
  end

  // Flatten the window: element (r,c) at [(r*K+c)*DATA_W +: DATA_W]
  always_comb begin
    window_flat = '0;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        window_flat[(r*K+c)*DATA_W +: DATA_W] = win_q[r][c];
  end

  assign bus.window       = window_flat;
  assign bus.window_valid = window_valid_q;
  assign bus.frame_done   = frame_done_q;
  assign bus.out_row      = out_row_q;
  assign bus.out_col      = out_col_q;
endmodule

// File: tb/tb_window_gen.sv
// Bench for window_gen: three instances (K=3 6x6 stride 1, K=3 6x6 stride 2,
// K=5 8x8 stride 1) checked against a frame-array reference model.
module tb_window_gen;
  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUTs ----------------
  window_gen_if #(.DATA_W(8), .KERNEL(3), .IMG_W(6), .IMG_H(6)) if_a ();
  window_gen_if #(.DATA_W(8), .KERNEL(3), .IMG_W(6), .IMG_H(6)) if_b ();
  window_gen_if #(.DATA_W(8), .KERNEL(5), .IMG_W(8), .IMG_H(8)) if_c ();

  window_gen #(.DATA_W(8), .KERNEL(3), .IMG_W(6), .IMG_H(6), .STRIDE(1))
    dut_a (.clk(clk), .rst(rst), .bus(if_a));
  window_gen #(.DATA_W(8), .KERNEL(3), .IMG_W(6), .IMG_H(6), .STRIDE(2))
    dut_b (.clk(clk), .rst(rst), .bus(if_b));
  window_gen #(.DATA_W(8), .KERNEL(5), .IMG_W(8), .IMG_H(8), .STRIDE(1))
    dut_c (.clk(clk), .rst(rst), .bus(if_c));

  logic       pv_ab = 1'b0, sof_ab = 1'b0;
  logic [7:0] pix_ab = '0;
  logic       pv_c = 1'b0, sof_c = 1'b0;
  logic [7:0] pix_c = '0;
  assign if_a.pixel_valid = pv_ab;  assign if_a.sof = sof_ab;  assign if_a.pixel_in = pix_ab;
  assign if_b.pixel_valid = pv_ab;  assign if_b.sof = sof_ab;  assign if_b.pixel_in = pix_ab;
  assign if_c.pixel_valid = pv_c;   assign if_c.sof = sof_c;   assign if_c.pixel_in = pix_c;

  logic pv_seen_ab = 1'b0, pv_seen_c = 1'b0;
  always @(posedge clk) begin
    pv_seen_ab <= pv_ab;
    pv_seen_c  <= pv_c;
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [77:0]  exp_a[$], exp_b[$];
  logic [205:0] exp_c[$];
  int done_a[$], done_b[$], done_c[$];
  int win_cnt_a = 0, win_cnt_b = 0, win_cnt_c = 0;
  int done_cnt_a = 0, done_cnt_b = 0, done_cnt_c = 0;
  logic [77:0]  e_a, e_b;
  logic [205:0] e_c;
  int de_a, de_b, de_c;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: keeps the current frame as a 2-D array and cuts the
  // window directly out of it.
  logic [7:0] img_ab [6][6];
  logic [7:0] img_c  [8][8];
  int mr_ab = 0, mc_ab = 0, mr_c = 0, mc_c = 0;

  task automatic model_ab(input logic [7:0] v, input logic s);
    logic [71:0] w;
    if (s) begin mr_ab = 0; mc_ab = 0; end
    img_ab[mr_ab][mc_ab] = v;
    if (mr_ab >= 2 && mc_ab >= 2) begin
      for (int rr = 0; rr < 3; rr++)
        for (int cc = 0; cc < 3; cc++)
          w[(rr*3+cc)*8 +: 8] = img_ab[mr_ab-2+rr][mc_ab-2+cc];
      exp_a.push_back({3'(mr_ab-2), 3'(mc_ab-2), w});
      if (((mr_ab-2) % 2 == 0) && ((mc_ab-2) % 2 == 0))
        exp_b.push_back({3'((mr_ab-2)/2), 3'((mc_ab-2)/2), w});
    end
    if (mr_ab == 5 && mc_ab == 5) begin
      done_a.push_back(cyc + 1);
      done_b.push_back(cyc + 1);
    end
    mc_ab++;
    if (mc_ab == 6) begin mc_ab = 0; mr_ab++; if (mr_ab == 6) mr_ab = 0; end
  endtask

  task automatic model_c(input logic [7:0] v, input logic s);
    logic [199:0] w;
    if (s) begin mr_c = 0; mc_c = 0; end
    img_c[mr_c][mc_c] = v;
    if (mr_c >= 4 && mc_c >= 4) begin
      for (int rr = 0; rr < 5; rr++)
        for (int cc = 0; cc < 5; cc++)
          w[(rr*5+cc)*8 +: 8] = img_c[mr_c-4+rr][mc_c-4+cc];
      exp_c.push_back({3'(mr_c-4), 3'(mc_c-4), w});
    end
    if (mr_c == 7 && mc_c == 7) done_c.push_back(cyc + 1);
    mc_c++;
    if (mc_c == 8) begin mc_c = 0; mr_c++; if (mr_c == 8) mr_c = 0; end
  endtask

  // ---------------- drivers ----------------
  task automatic idle_ab();
    @(posedge clk); #1;
    pv_ab = 1'b0; sof_ab = 1'b0;
  endtask

  task automatic send_ab(input logic [7:0] v, input logic s);
    @(posedge clk); #1;
    pv_ab = 1'b1; sof_ab = s; pix_ab = v;
    model_ab(v, s);
  endtask

  task automatic frame_ab(input int base, input logic with_sof, input logic gaps);
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 6; c++) begin
        if (gaps) while ($urandom_range(0, 99) < 40) idle_ab();
        send_ab(8'(base + r*6 + c), with_sof && r == 0 && c == 0);
      end
  endtask

  task automatic partial_ab(input int n);
    for (int i = 0; i < n; i++) send_ab(8'(i), i == 0);
  endtask

  task automatic idle_c();
    @(posedge clk); #1;
    pv_c = 1'b0; sof_c = 1'b0;
  endtask

  task automatic send_c(input logic [7:0] v, input logic s);
    @(posedge clk); #1;
    pv_c = 1'b1; sof_c = s; pix_c = v;
    model_c(v, s);
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (if_a.window_valid) begin
      win_cnt_a++;
      check("a_accept_before_valid", pv_seen_ab, 1);
      check("a_window_expected", exp_a.size() != 0, 1);
      if (exp_a.size() != 0) begin
        e_a = exp_a.pop_front();
        check("a_window", {if_a.out_row, if_a.out_col, if_a.window}, e_a);
      end
    end
    if (if_a.frame_done) begin
      done_cnt_a++;
      check("a_done_expected", done_a.size() != 0, 1);
      if (done_a.size() != 0) begin
        de_a = done_a.pop_front();
        check("a_done_cycle", cyc, de_a);
      end
    end
    if (if_b.window_valid) begin
      win_cnt_b++;
      check("b_accept_before_valid", pv_seen_ab, 1);
      check("b_window_expected", exp_b.size() != 0, 1);
      if (exp_b.size() != 0) begin
        e_b = exp_b.pop_front();
        check("b_window", {if_b.out_row, if_b.out_col, if_b.window}, e_b);
      end
    end
    if (if_b.frame_done) begin
      done_cnt_b++;
      check("b_done_expected", done_b.size() != 0, 1);
      if (done_b.size() != 0) begin
        de_b = done_b.pop_front();
        check("b_done_cycle", cyc, de_b);
      end
    end
    if (if_c.window_valid) begin
      win_cnt_c++;
      check("c_accept_before_valid", pv_seen_c, 1);
      check("c_window_expected", exp_c.size() != 0, 1);
      if (exp_c.size() != 0) begin
        e_c = exp_c.pop_front();
        check("c_window", {if_c.out_row, if_c.out_col, if_c.window}, e_c);
      end
    end
    if (if_c.frame_done) begin
      done_cnt_c++;
      check("c_done_expected", done_c.size() != 0, 1);
      if (done_c.size() != 0) begin
        de_c = done_c.pop_front();
        check("c_done_cycle", cyc, de_c);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_a_valid",  if_a.window_valid, 0);
    check("rst_a_done",   if_a.frame_done, 0);
    check("rst_a_window", if_a.window, 0);
    check("rst_a_coords", {if_a.out_row, if_a.out_col}, 0);
    check("rst_b_valid",  if_b.window_valid, 0);
    check("rst_c_valid",  if_c.window_valid, 0);
    check("rst_c_window", if_c.window, 0);

    // Clean frame, then gapped frame, then back-to-back frame without sof
    frame_ab(0, 1'b1, 1'b0);
    frame_ab(0, 1'b1, 1'b1);
    frame_ab(100, 1'b0, 1'b0);
    repeat (3) idle_ab();

    // Mid-frame sof abandons the partial frame
    partial_ab(20);
    frame_ab(50, 1'b1, 1'b0);
    repeat (3) idle_ab();

    // Mid-frame reset; next frame starts at (0,0) without sof
    partial_ab(20);
    @(posedge clk); #1;
    pv_ab = 1'b0; sof_ab = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    mr_ab = 0; mc_ab = 0;
    @(negedge clk);
    check("midrst_a_valid",  if_a.window_valid, 0);
    check("midrst_a_window", if_a.window, 0);
    check("midrst_b_valid",  if_b.window_valid, 0);
    check("midrst_b_window", if_b.window, 0);
    frame_ab(0, 1'b0, 1'b0);
    repeat (3) idle_ab();

    // K=5 checkerboard of extreme values, then a random frame
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        send_c(((r + c) % 2 == 1) ? 8'h7f : 8'h80, r == 0 && c == 0);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        if ($urandom_range(0, 99) < 30) idle_c();
        send_c(8'($urandom_range(0, 255)), 1'b0);
      end
    repeat (4) idle_c();

    // Drain and totals
    check("a_queue_empty", exp_a.size(), 0);
    check("b_queue_empty", exp_b.size(), 0);
    check("c_queue_empty", exp_c.size(), 0);
    check("a_done_queue_empty", done_a.size(), 0);
    check("c_done_queue_empty", done_c.size(), 0);
    check("a_window_count", win_cnt_a, 88);
    check("b_window_count", win_cnt_b, 24);
    check("c_window_count", win_cnt_c, 32);
    check("a_done_count", done_cnt_a, 5);
    check("b_done_count", done_cnt_b, 5);
    check("c_done_count", done_cnt_c, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
